// File: rtl/irq_capture.sv
// Interrupt capture front-end: synchronizes raw lines, detects edge/level events,
// latches sticky pending/overflow bits and offers the lowest-index unmasked source.
module irq_capture #(
  parameter  int unsigned NUM_SRC     = 4,
  parameter  int unsigned SYNC_STAGES = 2,
  localparam int unsigned ID_W        = $clog2(NUM_SRC)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] irq_raw,
  input  logic [NUM_SRC-1:0] cfg_edge,
  input  logic [NUM_SRC-1:0] cfg_mask,
  input  logic [NUM_SRC-1:0] clr_vec,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] overflow,
  output logic               irq_out,
  output logic               claim_valid,
  input  logic               claim_ready,
  output logic [ID_W-1:0]    claim_id,
  output logic [NUM_SRC-1:0] claim_vec
);

  typedef enum logic {
    C_IDLE,
    C_OFFER
  } claim_state_e;

  claim_state_e state_q, state_d;

  logic [SYNC_STAGES-1:0][NUM_SRC-1:0] sync_q, sync_d;
  logic [NUM_SRC-1:0] hist_q, hist_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] overflow_q, overflow_d;
  logic               claim_valid_q, claim_valid_d;
  logic [ID_W-1:0]    claim_id_q, claim_id_d;
  logic [NUM_SRC-1:0] claim_vec_q, claim_vec_d;

  logic [NUM_SRC-1:0] sync_s;
  logic [NUM_SRC-1:0] ev;
  logic [NUM_SRC-1:0] acc;
  logic [NUM_SRC-1:0] clr_any;
  logic [NUM_SRC-1:0] req;
  logic [ID_W-1:0]    sel_id;

  // Synchronizer shift chain and edge history
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], irq_raw};
    sync_s = sync_q[SYNC_STAGES-1];
    hist_d = sync_s;
  end

  // Event detection and sticky pending/overflow; a new event always beats a clear
  always_comb begin
    ev         = (sync_s & ~hist_q & cfg_edge) | (sync_s & ~cfg_edge);
    acc        = {NUM_SRC{claim_valid_q & claim_ready}} & claim_vec_q;
    clr_any    = clr_vec | acc;
    pending_d  = ev | (pending_q & ~clr_any);
    overflow_d = (cfg_edge & ev & pending_q & ~clr_any) | (overflow_q & ~clr_vec);
  end

  // Lowest-index unmasked pending source
  always_comb begin
    req    = pending_q & cfg_mask;
    sel_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        sel_id = ID_W'(i);
      end
    end
  end

  // Claim FSM: offer is frozen until accepted, then one idle cycle before the next
  always_comb begin
    state_d       = state_q;
    claim_valid_d = claim_valid_q;
    claim_id_d    = claim_id_q;
    claim_vec_d   = claim_vec_q;
    unique case (state_q)
      C_IDLE: begin
        if (|req) begin
          state_d       = C_OFFER;
          claim_valid_d = 1'b1;
          claim_id_d    = sel_id;
          claim_vec_d   = NUM_SRC'(1) << sel_id;
        end
      end
      C_OFFER: begin
        if (claim_ready) begin
          state_d       = C_IDLE;
          claim_valid_d = 1'b0;
          claim_vec_d   = '0;
        end
      end
      default: begin
        state_d       = C_IDLE;
        claim_valid_d = 1'b0;
        claim_vec_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= C_IDLE;
      sync_q        <= '0;
      hist_q        <= '0;
      pending_q     <= '0;
      overflow_q    <= '0;
      claim_valid_q <= 1'b0;
      claim_id_q    <= '0;
      claim_vec_q   <= '0;
    end else begin
      state_q       <= state_d;
      sync_q        <= sync_d;
      hist_q        <= hist_d;
      pending_q     <= pending_d;
      overflow_q    <= overflow_d;
      claim_valid_q <= claim_valid_d;
      claim_id_q    <= claim_id_d;
      claim_vec_q   <= claim_vec_d;
    end
  end

  assign pending     = pending_q;
  assign overflow    = overflow_q;
  assign claim_valid = claim_valid_q;
  assign claim_id    = claim_id_q;
  assign claim_vec   = claim_vec_q;
  assign irq_out     = |(pending_q & cfg_mask);

endmodule

// File: tb/tb_irq_capture.sv
// Directed self-checking bench for irq_capture (NUM_SRC=4, SYNC_STAGES=2).
module tb_irq_capture;

  localparam int unsigned NUM_SRC = 4;
  localparam int unsigned ID_W    = 2;

  logic               clk;
  logic               rst_n;
  logic [NUM_SRC-1:0] irq_raw;
  logic [NUM_SRC-1:0] cfg_edge;
  logic [NUM_SRC-1:0] cfg_mask;
  logic [NUM_SRC-1:0] clr_vec;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] overflow;
  logic               irq_out;
  logic               claim_valid;
  logic               claim_ready;
  logic [ID_W-1:0]    claim_id;
  logic [NUM_SRC-1:0] claim_vec;

  int n_cmp = 0;
  int n_bad = 0;

  irq_capture #(.NUM_SRC(NUM_SRC), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .irq_raw     (irq_raw),
    .cfg_edge    (cfg_edge),
    .cfg_mask    (cfg_mask),
    .clr_vec     (clr_vec),
    .pending     (pending),
    .overflow    (overflow),
    .irq_out     (irq_out),
    .claim_valid (claim_valid),
    .claim_ready (claim_ready),
    .claim_id    (claim_id),
    .claim_vec   (claim_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n       = 1'b1;
    irq_raw     = '0;
    cfg_edge    = 4'hF;
    cfg_mask    = 4'hF;
    clr_vec     = '0;
    claim_ready = 1'b0;
    #1 rst_n = 1'b0;
    tick(2);
    chk("rst_pending", 32'(pending), 32'h0);
    chk("rst_overflow", 32'(overflow), 32'h0);
    chk("rst_valid", 32'(claim_valid), 32'h0);
    chk("rst_id", 32'(claim_id), 32'h0);
    chk("rst_vec", 32'(claim_vec), 32'h0);
    chk("rst_irq", 32'(irq_out), 32'h0);
    rst_n = 1'b1;
    tick(2);

    // Edge on source 1, then accept
    irq_raw = 4'h2;
    tick(3);
    chk("t1_pending", 32'(pending), 32'h2);
    chk("t1_valid_early", 32'(claim_valid), 32'h0);
    irq_raw = 4'h0;
    tick();
    chk("t1_valid", 32'(claim_valid), 32'h1);
    chk("t1_id", 32'(claim_id), 32'h1);
    chk("t1_vec", 32'(claim_vec), 32'h2);
    chk("t1_irq", 32'(irq_out), 32'h1);
    claim_ready = 1'b1;
    tick();
    claim_ready = 1'b0;
    chk("t1_acc_pending", 32'(pending), 32'h0);
    chk("t1_acc_irq", 32'(irq_out), 32'h0);
    chk("t1_acc_valid", 32'(claim_valid), 32'h0);
    chk("t1_acc_vec", 32'(claim_vec), 32'h0);

    // Level source 2 re-asserts after accept
    cfg_edge = 4'hB;
    irq_raw  = 4'h4;
    tick(3);
    chk("t2_pending", 32'(pending), 32'h4);
    tick();
    chk("t2_valid", 32'(claim_valid), 32'h1);
    chk("t2_id", 32'(claim_id), 32'h2);
    claim_ready = 1'b1;
    tick();
    claim_ready = 1'b0;
    chk("t2_reset_pending", 32'(pending), 32'h4);
    chk("t2_idle_gap", 32'(claim_valid), 32'h0);
    tick();
    chk("t2_valid2", 32'(claim_valid), 32'h1);
    chk("t2_id2", 32'(claim_id), 32'h2);
    irq_raw = 4'h0;
    tick(2);
    clr_vec = 4'h4;
    tick();
    clr_vec = 4'h0;
    chk("t2_clr_pending", 32'(pending), 32'h0);
    chk("t2_offer_held", 32'(claim_valid), 32'h1);
    chk("t2_id_held", 32'(claim_id), 32'h2);
    chk("t2_no_ovf", 32'(overflow), 32'h0);
    claim_ready = 1'b1;
    tick();
    claim_ready = 1'b0;
    chk("t2_done", 32'(claim_valid), 32'h0);
    cfg_edge = 4'hF;
    tick(2);

    // Simultaneous sources 0 and 3 with ready held
    irq_raw     = 4'h9;
    claim_ready = 1'b1;
    tick(3);
    chk("t3_pending", 32'(pending), 32'h9);
    chk("t3_valid0", 32'(claim_valid), 32'h0);
    irq_raw = 4'h0;
    tick();
    chk("t3_v_a", 32'(claim_valid), 32'h1);
    chk("t3_id_a", 32'(claim_id), 32'h0);
    chk("t3_vec_a", 32'(claim_vec), 32'h1);
    tick();
    chk("t3_gap", 32'(claim_valid), 32'h0);
    chk("t3_pend_mid", 32'(pending), 32'h8);
    tick();
    chk("t3_v_b", 32'(claim_valid), 32'h1);
    chk("t3_id_b", 32'(claim_id), 32'h3);
    tick();
    chk("t3_end_valid", 32'(claim_valid), 32'h0);
    chk("t3_end_pend", 32'(pending), 32'h0);
    claim_ready = 1'b0;
    tick(3);

    // Overflow on source 0, clear, and set-beats-clear
    irq_raw = 4'h1;
    tick(2);
    irq_raw = 4'h0;
    tick(2);
    chk("t4_pending", 32'(pending), 32'h1);
    chk("t4_valid", 32'(claim_valid), 32'h1);
    irq_raw = 4'h1;
    tick(2);
    irq_raw = 4'h0;
    tick();
    chk("t4_pend2", 32'(pending), 32'h1);
    chk("t4_ovf", 32'(overflow), 32'h1);
    clr_vec = 4'h1;
    tick();
    clr_vec = 4'h0;
    chk("t4_clr_pend", 32'(pending), 32'h0);
    chk("t4_clr_ovf", 32'(overflow), 32'h0);
    chk("t4_offer_held", 32'(claim_valid), 32'h1);
    claim_ready = 1'b1;
    tick();
    claim_ready = 1'b0;
    chk("t4_acc_valid", 32'(claim_valid), 32'h0);
    irq_raw = 4'h1;
    tick(2);
    clr_vec = 4'h1;
    tick();
    clr_vec = 4'h0;
    irq_raw = 4'h0;
    chk("t4_set_wins", 32'(pending), 32'h1);
    chk("t4_ovf_clean", 32'(overflow), 32'h0);
    tick();
    chk("t4_valid3", 32'(claim_valid), 32'h1);
    claim_ready = 1'b1;
    tick();
    claim_ready = 1'b0;
    chk("t4_final_pend", 32'(pending), 32'h0);
    tick(3);

    // Masked events latch but do not claim
    cfg_mask = 4'h0;
    irq_raw  = 4'hA;
    tick(3);
    chk("t5_pending", 32'(pending), 32'hA);
    chk("t5_irq_masked", 32'(irq_out), 32'h0);
    irq_raw = 4'h0;
    tick();
    chk("t5_no_claim", 32'(claim_valid), 32'h0);
    cfg_mask = 4'h8;
    #1;
    chk("t5_irq_comb", 32'(irq_out), 32'h1);
    tick();
    chk("t5_valid", 32'(claim_valid), 32'h1);
    chk("t5_id", 32'(claim_id), 32'h3);
    chk("t5_vec", 32'(claim_vec), 32'h8);

    // Asynchronous reset during an offer
    #2 rst_n = 1'b0;
    #1;
    chk("t6_pending", 32'(pending), 32'h0);
    chk("t6_overflow", 32'(overflow), 32'h0);
    chk("t6_valid", 32'(claim_valid), 32'h0);
    chk("t6_id", 32'(claim_id), 32'h0);
    chk("t6_vec", 32'(claim_vec), 32'h0);
    chk("t6_irq", 32'(irq_out), 32'h0);
    cfg_mask = 4'hF;
    tick();
    rst_n = 1'b1;
    tick(6);
    chk("t6_post_valid", 32'(claim_valid), 32'h0);
    chk("t6_post_pend", 32'(pending), 32'h0);
    chk("t6_post_irq", 32'(irq_out), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
